evt_sync_merger: RTL and testbench
==================================

EVT_SYNC_MERGER -- requirements
Module: evt_sync_merger

Interface
REQ-001 Parameter SIZE, default 65, width of one stream word; bit SIZE-1 is the metadata flag and bits SIZE-2:0 are the payload.
REQ-002 Parameter TOTAL_INPUTS, default 2, number of input FIFO read ports merged; range 2..8.
REQ-003 Parameter CNT_WIDTH, default 16, width of the merged-event counter.
REQ-004 clock  input  1  single clock; all logic is synchronous to its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_data  input  [SIZE-1:0] x TOTAL_INPUTS  head word of each first-word-fall-through (FWFT) input FIFO.
REQ-007 in_empty  input  TOTAL_INPUTS  per-input FIFO empty; in_data[i] is valid only when in_empty[i]=0.
REQ-008 in_ren  output  TOTAL_INPUTS  per-input pop strobe.
REQ-009 out_data  output  [SIZE-1:0]  word written to the downstream FIFO.
REQ-010 out_wen  output  1  write strobe for out_data.
REQ-011 out_almost_full  input  1  downstream back-pressure; at least 2 free entries remain while low.
REQ-012 err_l0id  output  1  one-cycle pulse on an L0ID mismatch between inputs.
REQ-013 err_desync  output  1  one-cycle pulse when a non-header word is discarded while waiting for a header.
REQ-014 evt_count  output  [CNT_WIDTH-1:0]  number of merged events emitted.

Function
REQ-015 A header word has meta=1 and payload[63:56]=8'hAB; its L0ID is payload[31:0].
REQ-016 A footer word has meta=1 and payload[63:56]=8'hCD; all other words are data words.
REQ-017 FSM states: WAIT_HDR, CHECK, EMIT_HDR, DRAIN, NEXT.
REQ-018 WAIT_HDR:
- If any non-empty input has a non-header word at its head, pop that word and pulse err_desync.
- Any number of inputs may be popped in the same cycle.
- Go to CHECK only when every input is non-empty with a header at its head.
REQ-019 CHECK:
- Compare the L0ID of every input with the L0ID of input 0.
- On any mismatch, pulse err_l0id; the event is still merged.
- Go to EMIT_HDR.
REQ-020 EMIT_HDR:
- When out_almost_full=0, write the input-0 header and pop every input's header in the same cycle.
- Set index i=0 and go to DRAIN.
REQ-021 DRAIN (input i):
- While in_empty[i]=0 and out_almost_full=0, pop one word per cycle.
- Forward data words.
- On a footer, drop it unless i=TOTAL_INPUTS-1, then go to NEXT.
REQ-022 NEXT:
- If i<TOTAL_INPUTS-1, increment i and return to DRAIN.
- Otherwise increment evt_count and return to WAIT_HDR.
REQ-023 Output is registered: out_data/out_wen assert exactly 1 cycle after the pop cycle that produced the word.
REQ-024 in_ren[i] never asserts while in_empty[i]=1; only the active input is popped in DRAIN.
REQ-025 out_almost_full sampled high stalls pops in the same cycle; no word is lost or duplicated.
REQ-026 evt_count wraps from all-ones to 0 with no flag.
REQ-027 A header arriving on input i during DRAIN of i is treated as a data word (no nesting).

Reset
REQ-028 While reset=1:
- FSM is forced to WAIT_HDR and i=0.
- in_ren=0, out_wen=0, out_data=0, err_l0id=0, err_desync=0, evt_count=0.
REQ-029 Reset mid-event abandons the event; any partial output already written stays in the downstream FIFO.

Structure
REQ-030 The shared package evt_sync_pkg holds:
- the constants HDR_FLAG=8'hAB and FTR_FLAG=8'hCD;
- the L0ID field bounds;
- the FSM state enum.
REQ-031 A single sub-module evt_word_decode (combinational: is_header, is_footer, l0id) is instantiated once per input.

Verification
REQ-032 Two inputs, each with a header (L0ID=5), 3 data words and a footer, out_almost_full=0:
- output is 1 header, 6 data words in order in0 then in1, and 1 footer (8 writes);
- evt_count=1; no error pulses.
REQ-033 Header L0IDs 5 and 6 -> err_l0id pulses once; merged output is still emitted with L0ID 5.
REQ-034 Input 1 head is the data word 0x0_DEAD before its header -> word popped, err_desync pulses once, then a normal merge.
REQ-035 out_almost_full toggled every 2 cycles during DRAIN -> output word sequence identical to REQ-032 with no duplicates.
REQ-036 reset asserted on the 3rd data pop -> all outputs 0 next cycle; the next full event merges correctly with evt_count=1.
REQ-037 CNT_WIDTH=4 with 17 events -> evt_count reads 1.

Source files
------------

// File: rtl/evt_sync_pkg.sv
// Shared constants and types for the event synchronising merger.
package evt_sync_pkg;

    // Marker byte values carried in payload[63:56] of metadata words
    localparam logic [7:0] HDR_FLAG = 8'hAB;
    localparam logic [7:0] FTR_FLAG = 8'hCD;

    // Payload field bounds
    localparam int FLAG_HI = 63;
    localparam int FLAG_LO = 56;
    localparam int L0ID_HI = 31;
    localparam int L0ID_LO = 0;
    localparam int L0ID_W  = L0ID_HI - L0ID_LO + 1;

    // Merge sequencer states
    typedef enum logic [2:0] {
        WAIT_HDR,
        CHECK,
        EMIT_HDR,
        DRAIN,
        NEXT
    } merge_state_t;

    // True when a metadata word carries the given marker byte
    function automatic logic flag_match(input logic meta, input logic [7:0] flag,
                                        input logic [7:0] want);
        return meta && (flag == want);
    endfunction

endpackage

// File: rtl/evt_word_decode.sv
// Classifies one stream word: header, footer or plain data, plus its L0ID field.
module evt_word_decode
    import evt_sync_pkg::*;
#(
    parameter int SIZE = 65
) (
    input  logic [SIZE-1:0]   word,
    output logic              is_header,
    output logic              is_footer,
    output logic [L0ID_W-1:0] l0id
);

    logic       meta;
    logic [7:0] flag;
    // Only the flag byte and L0ID are interpreted; the rest is opaque payload.
    logic       unused_word;

    assign meta        = word[SIZE-1];
    assign flag        = word[FLAG_HI:FLAG_LO];
    assign is_header   = flag_match(meta, flag, HDR_FLAG);
    assign is_footer   = flag_match(meta, flag, FTR_FLAG);
    assign l0id        = word[L0ID_HI:L0ID_LO];
    assign unused_word = ^word;

endmodule

// File: rtl/evt_sync_merger.sv
// Merges one event from each FWFT input FIFO into a single output stream:
// one header (from input 0), the data words of every input in index order,
// and the footer of the last input.
module evt_sync_merger
    import evt_sync_pkg::*;
#(
    parameter int SIZE         = 65,
    parameter int TOTAL_INPUTS = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic [TOTAL_INPUTS-1:0][SIZE-1:0]       in_data,
    input  logic [TOTAL_INPUTS-1:0]                 in_empty,
    output logic [TOTAL_INPUTS-1:0]                 in_ren,
    output logic [SIZE-1:0]                         out_data,
    output logic                                    out_wen,
    input  logic                                    out_almost_full,
    output logic                                    err_l0id,
    output logic                                    err_desync,
    output logic [CNT_WIDTH-1:0]                    evt_count
);

    localparam int IDX_W = (TOTAL_INPUTS > 1) ? $clog2(TOTAL_INPUTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_INPUTS - 1);

    merge_state_t state;
    logic [IDX_W-1:0] idx;

    logic [TOTAL_INPUTS-1:0]             is_hdr;
    logic [TOTAL_INPUTS-1:0]             is_ftr;
    logic [TOTAL_INPUTS-1:0][L0ID_W-1:0] l0id;

    logic [TOTAL_INPUTS-1:0] desync_mask;
    logic                    all_hdr;
    logic                    l0id_mismatch;
    logic                    drain_pop;
    logic [TOTAL_INPUTS-1:0] ren_c;

    // One decoder per input head word
    genvar gi;
    generate
        for (gi = 0; gi < TOTAL_INPUTS; gi++) begin : g_dec
            evt_word_decode #(.SIZE(SIZE)) u_dec (
                .word      (in_data[gi]),
                .is_header (is_hdr[gi]),
                .is_footer (is_ftr[gi]),
                .l0id      (l0id[gi])
            );
        end
    endgenerate

    // Head-of-FIFO summaries used while hunting for a header set
    always_comb begin
        desync_mask   = '0;
        all_hdr       = 1'b1;
        l0id_mismatch = 1'b0;
        for (int i = 0; i < TOTAL_INPUTS; i++) begin
            desync_mask[i] = !in_empty[i] && !is_hdr[i];
            if (in_empty[i] || !is_hdr[i])
                all_hdr = 1'b0;
            if (l0id[i] != l0id[0])
                l0id_mismatch = 1'b1;
        end
    end

    // The active input in DRAIN may advance only when it has a word and downstream has room
    assign drain_pop = !in_empty[idx] && !out_almost_full;

    // Pop strobes: combinational so a pop lands in the same cycle the head word is consumed
    always_comb begin
        ren_c = '0;
        unique case (state)
            WAIT_HDR: ren_c = desync_mask;
            EMIT_HDR: if (!out_almost_full) ren_c = ~in_empty;
            DRAIN:    if (drain_pop) ren_c[idx] = 1'b1;
            default:  ren_c = '0;
        endcase
        if (reset)
            ren_c = '0;
    end

    assign in_ren = ren_c;

    // Merge sequencer with registered output word, strobes and counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= WAIT_HDR;
            idx        <= '0;
            out_wen    <= 1'b0;
            out_data   <= '0;
            err_l0id   <= 1'b0;
            err_desync <= 1'b0;
            evt_count  <= '0;
        end else begin
            out_wen    <= 1'b0;
            err_l0id   <= 1'b0;
            err_desync <= 1'b0;
            unique case (state)
                WAIT_HDR: begin
                    err_desync <= |desync_mask;
                    if (all_hdr)
                        state <= CHECK;
                end
                CHECK: begin
                    // A mismatch is reported but the event is merged anyway
                    err_l0id <= l0id_mismatch;
                    state    <= EMIT_HDR;
                end
                EMIT_HDR: begin
                    if (!out_almost_full) begin
                        out_data <= in_data[0];
                        out_wen  <= 1'b1;
                        idx      <= '0;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Headers seen here are treated as data; only a footer ends the input
                    if (drain_pop) begin
                        if (is_ftr[idx]) begin
                            if (idx == LAST_IDX) begin
                                out_data <= in_data[idx];
                                out_wen  <= 1'b1;
                            end
                            state <= NEXT;
                        end else begin
                            out_data <= in_data[idx];
                            out_wen  <= 1'b1;
                        end
                    end
                end
                NEXT: begin
                    if (idx != LAST_IDX) begin
                        idx   <= idx + IDX_W'(1);
                        state <= DRAIN;
                    end else begin
                        evt_count <= evt_count + CNT_WIDTH'(1);
                        state     <= WAIT_HDR;
                    end
                end
                default: state <= WAIT_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_evt_sync_merger.sv
// Randomised bench for evt_sync_merger with queue-based FIFO models and an
// event-level reference model of the merged stream.
module tb_evt_sync_merger;

    localparam int SZ = 65;
    localparam int NI = 2;
    localparam int CW = 4;

    typedef logic [SZ-1:0] word_t;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [NI-1:0][SZ-1:0]  in_data;
    logic [NI-1:0]          in_empty;
    logic [NI-1:0]          in_ren;
    logic [SZ-1:0]          out_data;
    logic                   out_wen;
    logic                   out_almost_full;
    logic                   err_l0id;
    logic                   err_desync;
    logic [CW-1:0]          evt_count;

    evt_sync_merger #(.SIZE(SZ), .TOTAL_INPUTS(NI), .CNT_WIDTH(CW)) dut (
        .clock           (clock),
        .reset           (reset),
        .in_data         (in_data),
        .in_empty        (in_empty),
        .in_ren          (in_ren),
        .out_data        (out_data),
        .out_wen         (out_wen),
        .out_almost_full (out_almost_full),
        .err_l0id        (err_l0id),
        .err_desync      (err_desync),
        .evt_count       (evt_count)
    );

    always #5 clock = ~clock;

    word_t fifo [NI][$];
    word_t got[$];
    word_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    desync_seen = 0, l0id_seen = 0;
    int    exp_desync = 0, exp_l0id = 0, exp_cnt = 0;
    int    pops0 = 0;

    function automatic word_t rand_word();
        return {1'($urandom_range(0, 1)), 32'($urandom()), 32'($urandom())};
    endfunction

    // Data word: never a footer; sometimes shaped like a header
    function automatic word_t rand_data();
        word_t w = rand_word();
        if ($urandom_range(0, 7) == 0) w[64:56] = 9'h1AB;
        if (w[64] && w[63:56] == 8'hCD) w[56] = ~w[56];
        return w;
    endfunction

    // Word that is not a header, as found ahead of a header after a desync
    function automatic word_t rand_junk();
        word_t w = rand_word();
        if (w[64] && w[63:56] == 8'hAB) w[56] = ~w[56];
        return w;
    endfunction

    function automatic word_t mk_hdr(input logic [31:0] id);
        return {1'b1, 8'hAB, 24'($urandom()), id};
    endfunction

    function automatic word_t mk_ftr();
        return {1'b1, 8'hCD, 24'($urandom()), 32'($urandom())};
    endfunction

    // Queue one event on both inputs and extend the expected merged stream
    task automatic add_event(input logic [31:0] id0, input logic [31:0] id1,
                             input int nd0, input int nd1, input int nj0, input int nj1);
        word_t w;
        for (int j = 0; j < nj0; j++) fifo[0].push_back(rand_junk());
        for (int j = 0; j < nj1; j++) fifo[1].push_back(rand_junk());
        exp_desync += (nj0 > nj1) ? nj0 : nj1;
        w = mk_hdr(id0);
        fifo[0].push_back(w);
        exp_q.push_back(w);
        fifo[1].push_back(mk_hdr(id1));
        if (id0 != id1) exp_l0id++;
        for (int d = 0; d < nd0; d++) begin
            w = rand_data(); fifo[0].push_back(w); exp_q.push_back(w);
        end
        fifo[0].push_back(mk_ftr());
        for (int d = 0; d < nd1; d++) begin
            w = rand_data(); fifo[1].push_back(w); exp_q.push_back(w);
        end
        w = mk_ftr();
        fifo[1].push_back(w);
        exp_q.push_back(w);
        exp_cnt++;
    endtask

    // One clock: drive FIFO heads, capture pops, apply them, log outputs
    task automatic step(input int amode, input bit rst);
        logic [NI-1:0] ren;
        reset = rst;
        case (amode)
            1:       out_almost_full = 1'($urandom_range(0, 1));
            2:       out_almost_full = ((cyc / 2) % 2) == 1;
            default: out_almost_full = 1'b0;
        endcase
        for (int i = 0; i < NI; i++) begin
            in_empty[i] = (fifo[i].size() == 0);
            in_data[i]  = in_empty[i] ? rand_word() : fifo[i][0];
        end
        #1;
        ren = in_ren;
        for (int i = 0; i < NI; i++) begin
            if (ren[i]) begin
                checks++;
                if (in_empty[i]) begin
                    failures++;
                    $display("FAIL ren_while_empty input=%0d got ren=1 want ren=0", i);
                end
            end
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < NI; i++)
            if (ren[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
        if (ren[0]) pops0++;
        if (out_wen) begin
            got.push_back(out_data);
            checks++;
            if (ren == '0) begin
                failures++;
                $display("FAIL wen_latency got wen=1 with no pop in previous cycle want pop");
            end
        end
        desync_seen += int'(err_desync);
        l0id_seen   += int'(err_l0id);
        cyc++;
        @(negedge clock);
    endtask

    task automatic clear_all();
        for (int i = 0; i < NI; i++) fifo[i].delete();
        got.delete();
        exp_q.delete();
        desync_seen = 0; l0id_seen = 0; exp_desync = 0; exp_l0id = 0;
    endtask

    task automatic run(input string name, input int amode, input int budget);
        bit done = 0;
        for (int n = 0; n < budget && !done; n++) begin
            step(amode, 1'b0);
            done = fifo[0].size() == 0 && fifo[1].size() == 0 &&
                   got.size() == exp_q.size() && evt_count == CW'(exp_cnt);
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_timeout got out_words=%0d want %0d within %0d cycles",
                     name, got.size(), exp_q.size(), budget);
        end
        for (int n = 0; n < 3; n++) step(amode, 1'b0);
    endtask

    task automatic check_results(input string name);
        checks++;
        if (got.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL %s_word_count got %0d want %0d", name, got.size(), exp_q.size());
        end
        for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
            checks++;
            if (got[k] !== exp_q[k]) begin
                failures++;
                $display("FAIL %s_word[%0d] got %h want %h", name, k, got[k], exp_q[k]);
            end
        end
        checks++;
        if (desync_seen != exp_desync) begin
            failures++;
            $display("FAIL %s_err_desync got %0d pulses want %0d", name, desync_seen, exp_desync);
        end
        checks++;
        if (l0id_seen != exp_l0id) begin
            failures++;
            $display("FAIL %s_err_l0id got %0d pulses want %0d", name, l0id_seen, exp_l0id);
        end
        checks++;
        if (evt_count !== CW'(exp_cnt)) begin
            failures++;
            $display("FAIL %s_evt_count got %0d want %0d", name, evt_count, CW'(exp_cnt));
        end
        clear_all();
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (out_wen !== 1'b0 || out_data !== '0 || err_l0id !== 1'b0 ||
            err_desync !== 1'b0 || evt_count !== '0) begin
            failures++;
            $display("FAIL %s_outputs got wen=%b data=%h l0=%b ds=%b cnt=%0d want all 0",
                     name, out_wen, out_data, err_l0id, err_desync, evt_count);
        end
    endtask

    task automatic do_reset();
        for (int n = 0; n < 2; n++) step(0, 1'b1);
        exp_cnt = 0;
        clear_all();
    endtask

    task automatic test_reset();
        // A pending non-header word would be popped if reset did not hold in_ren low
        fifo[0].push_back(rand_junk());
        for (int n = 0; n < 3; n++) step(0, 1'b1);
        checks++;
        if (in_ren !== '0) begin
            failures++;
            $display("FAIL reset_in_ren got %b want 00", in_ren);
        end
        check_idle_outputs("reset");
        exp_cnt = 0;
        clear_all();
    endtask

    task automatic test_basic();
        add_event(32'd5, 32'd5, 3, 3, 0, 0);
        run("basic", 0, 200);
        check_results("basic");
    endtask

    task automatic test_l0id_mismatch();
        add_event(32'd5, 32'd6, 3, 3, 0, 0);
        run("l0id", 0, 200);
        checks++;
        if (got.size() == 0 || got[0][31:0] !== 32'd5) begin
            failures++;
            $display("FAIL l0id_header got %h want L0ID 5", got.size() ? got[0] : '0);
        end
        check_results("l0id");
    endtask

    task automatic test_desync();
        fifo[1].push_back({1'b0, 64'hDEAD});
        exp_desync++;
        add_event(32'd7, 32'd7, 3, 3, 0, 0);
        run("desync", 0, 200);
        check_results("desync");
    endtask

    task automatic test_backpressure();
        add_event(32'd5, 32'd5, 3, 3, 0, 0);
        run("bp", 2, 400);
        check_results("bp");
    endtask

    task automatic test_reset_mid_event();
        bit hit = 0;
        do_reset();
        pops0 = 0;
        add_event(32'd9, 32'd9, 5, 3, 0, 0);
        // Header pop plus two data pops, then reset lands on the third data pop
        for (int n = 0; n < 50 && !hit; n++) begin
            step(0, 1'b0);
            hit = (pops0 == 3);
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL midreset_reach got %0d input0 pops want 3", pops0);
        end
        step(0, 1'b1);
        check_idle_outputs("midreset");
        exp_cnt = 0;
        clear_all();
        step(0, 1'b0);
        add_event(32'd10, 32'd10, 3, 3, 0, 0);
        run("midreset_next", 0, 200);
        check_results("midreset_next");
    endtask

    task automatic test_random();
        for (int e = 0; e < 12; e++)
            add_event($urandom(), ($urandom_range(0, 3) == 0) ? $urandom() : 32'hFFFF_FFFF,
                      $urandom_range(0, 5), $urandom_range(0, 5),
                      $urandom_range(0, 2), $urandom_range(0, 2));
        run("random", 1, 3000);
        check_results("random");
    endtask

    task automatic test_back_to_back();
        logic [31:0] id;
        for (int e = 0; e < 6; e++) begin
            id = $urandom();
            add_event(id, id, $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
        end
        run("b2b", 0, 1500);
        check_results("b2b");
    endtask

    task automatic test_count_wrap();
        logic [31:0] id;
        do_reset();
        for (int e = 0; e < 17; e++) begin
            id = $urandom();
            add_event(id, id, $urandom_range(0, 2), $urandom_range(0, 2), 0, 0);
        end
        run("wrap", 1, 4000);
        checks++;
        if (evt_count !== 4'd1) begin
            failures++;
            $display("FAIL wrap_17_events got %0d want 1", evt_count);
        end
        check_results("wrap");
    endtask

    initial begin
        reset = 1'b1;
        out_almost_full = 1'b0;
        in_empty = '1;
        in_data = '0;
        @(negedge clock);
        test_reset();
        test_basic();
        test_l0id_mismatch();
        test_desync();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_event();
        test_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
